// File: rtl/i3c_ctrl_pkg.sv
// Shared definitions for the I3C controller DAA / Hot-Join manager.
// Holds the bus-engine opcode enum, broadcast CCC codes, fixed addresses,
// the Hot-Join event byte and the manager FSM state enum.
package i3c_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_START   = 3'd0,
        OP_RESTART = 3'd1,
        OP_WRITE   = 3'd2,
        OP_READ    = 3'd3,
        OP_STOP    = 3'd4
    } be_op_t;

    localparam logic [7:0] CCC_ENEC   = 8'h00;
    localparam logic [7:0] CCC_DISEC  = 8'h01;
    localparam logic [7:0] CCC_RSTDAA = 8'h06;
    localparam logic [7:0] CCC_ENTDAA = 8'h07;

    localparam logic [6:0] BCAST_ADDR = 7'h7E;
    localparam logic [6:0] HJ_ADDR    = 7'h02;
    localparam logic [7:0] EVT_HJ     = 8'h08;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_IBI,
        ST_START,
        ST_BCAST_W,
        ST_CCC,
        ST_EVT,
        ST_CHK,
        ST_RESTART,
        ST_BCAST_R,
        ST_READ,
        ST_ADDR,
        ST_STOP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/i3c_daa_addr_pool.sv
// Dynamic address pool: counts assigned devices and produces the next
// address (DA_BASE + count) with its odd-parity bit.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clr         empty the pool
//   inc         one address was assigned (ignored when full)
//   count       number of assigned devices
//   next_da     address to hand out next
//   next_par    parity bit making {next_da, next_par} odd
//   full        count == MAX_DEV
module i3c_daa_addr_pool #(
    parameter int                    ADDR_WIDTH = 7,
    parameter logic [ADDR_WIDTH-1:0] DA_BASE    = 7'h10,
    parameter int                    MAX_DEV    = 8,
    localparam int                   CW         = $clog2(MAX_DEV + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [CW-1:0]         count,
    output logic [ADDR_WIDTH-1:0] next_da,
    output logic                  next_par,
    output logic                  full
);

    assign full     = (count == CW'(MAX_DEV));
    assign next_da  = DA_BASE + ADDR_WIDTH'(count);
    assign next_par = ~^next_da;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !full) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/i3c_ctrl_daa_hj_mgr.sv
// Controller-side Hot-Join / dynamic address manager.
// Answers Hot-Join IBIs, issues broadcast RSTDAA / ENEC / DISEC (HJ event)
// and runs the ENTDAA loop, driving the bit-level bus engine through a
// one-outstanding command/response handshake.
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   ibi_valid/addr/rnw              arbitration header won by bus engine
//   ibi_ready, ibi_ack              one-cycle accept pulse + ACK decision
//   be_cmd_valid/ready/op/data/last command channel to bus engine
//   be_rsp_valid/data/ack           response channel from bus engine
//   hj_en                           Hot-Join acceptance enable
//   rstdaa/entdaa/enec_hj/disec_hj_req  software request pulses
//   busy, done                      sequence status
//   err_pool_full                   sticky, cleared by a completed RSTDAA
//   dev_count                       number of assigned devices
//   new_dev_*                       per-assignment report (PID/BCR/DCR/DA)
//   hj_pending                      Hot-Join accepted, DAA not yet run
// Build option: define I3C_HJ_AUTO_DAA_EN to launch ENTDAA automatically
// right after an accepted Hot-Join.
module i3c_ctrl_daa_hj_mgr
    import i3c_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 7,
    parameter logic [ADDR_WIDTH-1:0] DA_BASE    = 7'h10,
    parameter int                    MAX_DEV    = 8,
    localparam int                   CW         = $clog2(MAX_DEV + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ibi_valid,
    input  logic [ADDR_WIDTH-1:0] ibi_addr,
    input  logic                  ibi_rnw,
    output logic                  ibi_ready,
    output logic                  ibi_ack,
    output logic                  be_cmd_valid,
    input  logic                  be_cmd_ready,
    output logic [2:0]            be_cmd_op,
    output logic [7:0]            be_cmd_data,
    output logic                  be_cmd_last,
    input  logic                  be_rsp_valid,
    input  logic [7:0]            be_rsp_data,
    input  logic                  be_rsp_ack,
    input  logic                  hj_en,
    input  logic                  rstdaa_req,
    input  logic                  entdaa_req,
    input  logic                  enec_hj_req,
    input  logic                  disec_hj_req,
    output logic                  busy,
    output logic                  done,
    output logic                  err_pool_full,
    output logic [CW-1:0]         dev_count,
    output logic                  new_dev_valid,
    output logic [ADDR_WIDTH-1:0] new_dev_da,
    output logic [47:0]           new_dev_pid,
    output logic [7:0]            new_dev_bcr,
    output logic [7:0]            new_dev_dcr,
    output logic                  hj_pending
);

    state_t                  state_q, state_d;
    be_op_t                  cmd_op;
    logic                    cmd_pend_q;
    logic [7:0]              ccc_q, ccc_sel;
    logic                    abort_q, ibi_ack_q;
    logic [2:0]              rd_cnt_q;
    logic [63:0]             dev_buf_q;
    logic                    issue, rsp_done, req_any, launch, auto_daa;
    logic                    set_abort, set_err, clr_hj, pool_clr, pool_inc;
    logic                    pool_full, next_par;
    logic [ADDR_WIDTH-1:0]   next_da;

    i3c_daa_addr_pool #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DA_BASE    (DA_BASE),
        .MAX_DEV    (MAX_DEV)
    ) u_pool (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pool_clr),
        .inc      (pool_inc),
        .count    (dev_count),
        .next_da  (next_da),
        .next_par (next_par),
        .full     (pool_full)
    );

`ifdef I3C_HJ_AUTO_DAA_EN
    assign auto_daa = hj_pending;
`else
    assign auto_daa = 1'b0;
`endif

    // A command is presented until accepted; afterwards only the response
    // is awaited, so the fields stay stable for free while stalled.
    assign be_cmd_valid = issue && !cmd_pend_q;
    assign be_cmd_op    = cmd_op;
    assign rsp_done     = cmd_pend_q && be_rsp_valid;

    always_comb begin
        req_any = 1'b1;
        ccc_sel = CCC_ENTDAA;
        if (auto_daa)          ccc_sel = CCC_ENTDAA;
        else if (rstdaa_req)   ccc_sel = CCC_RSTDAA;
        else if (disec_hj_req) ccc_sel = CCC_DISEC;
        else if (enec_hj_req)  ccc_sel = CCC_ENEC;
        else if (entdaa_req)   ccc_sel = CCC_ENTDAA;
        else                   req_any = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        cmd_op      = OP_START;
        be_cmd_data = '0;
        be_cmd_last = 1'b0;
        ibi_ready   = 1'b0;
        ibi_ack     = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        launch      = 1'b0;
        set_abort   = 1'b0;
        set_err     = 1'b0;
        clr_hj      = 1'b0;
        pool_clr    = 1'b0;
        pool_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (ibi_valid) begin
                    state_d = ST_IBI;
                end else if (req_any) begin
                    launch  = 1'b1;
                    clr_hj  = auto_daa;
                    state_d = ST_START;
                end
            end
            ST_IBI: begin
                busy      = 1'b0;
                ibi_ready = 1'b1;
                ibi_ack   = ibi_ack_q;
                state_d   = ST_IDLE;
            end
            ST_START: begin
                issue = 1'b1;
                if (rsp_done) state_d = ST_BCAST_W;
            end
            ST_BCAST_W: begin
                issue       = 1'b1;
                cmd_op      = OP_WRITE;
                be_cmd_data = {BCAST_ADDR, 1'b0};
                if (rsp_done) begin
                    set_abort = !be_rsp_ack;
                    state_d   = be_rsp_ack ? ST_CCC : ST_STOP;
                end
            end
            ST_CCC: begin
                issue       = 1'b1;
                cmd_op      = OP_WRITE;
                be_cmd_data = ccc_q;
                if (rsp_done) begin
                    if (ccc_q == CCC_ENTDAA)                           state_d = ST_CHK;
                    else if (ccc_q == CCC_ENEC || ccc_q == CCC_DISEC)  state_d = ST_EVT;
                    else                                               state_d = ST_STOP;
                end
            end
            ST_EVT: begin
                issue       = 1'b1;
                cmd_op      = OP_WRITE;
                be_cmd_data = EVT_HJ;
                if (rsp_done) state_d = ST_STOP;
            end
            ST_CHK: begin
                set_err = pool_full;
                state_d = pool_full ? ST_STOP : ST_RESTART;
            end
            ST_RESTART: begin
                issue  = 1'b1;
                cmd_op = OP_RESTART;
                if (rsp_done) state_d = ST_BCAST_R;
            end
            ST_BCAST_R: begin
                issue       = 1'b1;
                cmd_op      = OP_WRITE;
                be_cmd_data = {BCAST_ADDR, 1'b1};
                if (rsp_done) state_d = be_rsp_ack ? ST_READ : ST_STOP;
            end
            ST_READ: begin
                issue       = 1'b1;
                cmd_op      = OP_READ;
                be_cmd_last = (rd_cnt_q == 3'd7);
                if (rsp_done && rd_cnt_q == 3'd7) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                issue       = 1'b1;
                cmd_op      = OP_WRITE;
                be_cmd_data = 8'({next_da, next_par});
                if (rsp_done) begin
                    pool_inc = be_rsp_ack;
                    state_d  = ST_CHK;
                end
            end
            ST_STOP: begin
                issue  = 1'b1;
                cmd_op = OP_STOP;
                if (rsp_done) begin
                    clr_hj   = (ccc_q == CCC_ENTDAA);
                    pool_clr = (ccc_q == CCC_RSTDAA) && !abort_q;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_pend_q    <= 1'b0;
            ccc_q         <= '0;
            abort_q       <= 1'b0;
            ibi_ack_q     <= 1'b0;
            rd_cnt_q      <= '0;
            dev_buf_q     <= '0;
            hj_pending    <= 1'b0;
            err_pool_full <= 1'b0;
            new_dev_valid <= 1'b0;
            new_dev_da    <= '0;
            new_dev_pid   <= '0;
            new_dev_bcr   <= '0;
            new_dev_dcr   <= '0;
        end else begin
            new_dev_valid <= 1'b0;
            if (be_cmd_valid && be_cmd_ready) cmd_pend_q <= 1'b1;
            else if (rsp_done)                cmd_pend_q <= 1'b0;
            if (state_q == ST_IDLE && ibi_valid)
                ibi_ack_q <= (ibi_addr == HJ_ADDR) && !ibi_rnw && hj_en;
            if (state_q == ST_IBI && ibi_ack_q) hj_pending <= 1'b1;
            else if (clr_hj)                    hj_pending <= 1'b0;
            if (launch) begin
                ccc_q   <= ccc_sel;
                abort_q <= 1'b0;
            end
            if (set_abort) abort_q <= 1'b1;
            if (state_q == ST_BCAST_R && rsp_done) rd_cnt_q <= '0;
            // PID/BCR/DCR arrive MSB first, so shift left and the final
            // layout is {PID[47:0], BCR, DCR}.
            if (state_q == ST_READ && rsp_done) begin
                rd_cnt_q  <= rd_cnt_q + 1'b1;
                dev_buf_q <= {dev_buf_q[55:0], be_rsp_data};
            end
            if (pool_inc) begin
                new_dev_valid <= 1'b1;
                new_dev_da    <= next_da;
                new_dev_pid   <= dev_buf_q[63:16];
                new_dev_bcr   <= dev_buf_q[15:8];
                new_dev_dcr   <= dev_buf_q[7:0];
            end
            if (set_err)       err_pool_full <= 1'b1;
            else if (pool_clr) err_pool_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i3c_ctrl_daa_hj_mgr.sv
// Self-checking bench for i3c_ctrl_daa_hj_mgr (default build, auto-DAA off).
// A behavioural bus-engine/target model answers commands with random stalls
// and latencies; a sequence-level reference predicts the command stream,
// assignments, pool count, error flag and Hot-Join pending flag.
`timescale 1ns/1ps
module tb_i3c_ctrl_daa_hj_mgr;

    localparam int MAX_DEV = 4;
    localparam int CW      = $clog2(MAX_DEV + 1);

    localparam logic [2:0] C_START = 3'd0, C_RESTART = 3'd1, C_WRITE = 3'd2,
                           C_READ = 3'd3, C_STOP = 3'd4;

    logic clk = 1'b0;
    logic rst_n;
    logic ibi_valid, ibi_rnw, ibi_ready, ibi_ack;
    logic [6:0] ibi_addr;
    logic be_cmd_valid, be_cmd_ready, be_cmd_last;
    logic [2:0] be_cmd_op;
    logic [7:0] be_cmd_data, be_rsp_data;
    logic be_rsp_valid, be_rsp_ack;
    logic hj_en, rstdaa_req, entdaa_req, enec_hj_req, disec_hj_req;
    logic busy, done, err_pool_full, new_dev_valid, hj_pending;
    logic [CW-1:0] dev_count;
    logic [6:0] new_dev_da;
    logic [47:0] new_dev_pid;
    logic [7:0] new_dev_bcr, new_dev_dcr;

    always #5 clk = ~clk;

    i3c_ctrl_daa_hj_mgr #(
        .ADDR_WIDTH (7),
        .DA_BASE    (7'h10),
        .MAX_DEV    (MAX_DEV)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .ibi_valid (ibi_valid), .ibi_addr (ibi_addr), .ibi_rnw (ibi_rnw),
        .ibi_ready (ibi_ready), .ibi_ack (ibi_ack),
        .be_cmd_valid (be_cmd_valid), .be_cmd_ready (be_cmd_ready),
        .be_cmd_op (be_cmd_op), .be_cmd_data (be_cmd_data), .be_cmd_last (be_cmd_last),
        .be_rsp_valid (be_rsp_valid), .be_rsp_data (be_rsp_data), .be_rsp_ack (be_rsp_ack),
        .hj_en (hj_en), .rstdaa_req (rstdaa_req), .entdaa_req (entdaa_req),
        .enec_hj_req (enec_hj_req), .disec_hj_req (disec_hj_req),
        .busy (busy), .done (done), .err_pool_full (err_pool_full),
        .dev_count (dev_count), .new_dev_valid (new_dev_valid), .new_dev_da (new_dev_da),
        .new_dev_pid (new_dev_pid), .new_dev_bcr (new_dev_bcr), .new_dev_dcr (new_dev_dcr),
        .hj_pending (hj_pending)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scenario (written by the stimulus process only)
    int          sc_n;
    logic [63:0] sc_bytes [8];
    int          sc_nack  [8];
    logic        sc_bcast_ack;

    // Bus engine + targets (written by the engine process only)
    logic [11:0] cmd_log[$];
    int          reads_acc = 0;
    int          stall_viol = 0;
    int          e_nack [8];
    bit          e_asg  [8];
    bit          expect_hdr, pend, prev_stall, r;
    int          rd_idx, cur, dly;
    logic        p_ack;
    logic [7:0]  p_data;
    logic [11:0] prev_fields;
    logic [63:0] tmp;

    always @(negedge clk) begin
        if (!rst_n) begin
            be_cmd_ready = 1'b0;
            be_rsp_valid = 1'b0;
            be_rsp_ack   = 1'b0;
            be_rsp_data  = 8'h00;
            pend = 0; expect_hdr = 0; rd_idx = 0; cur = 0; prev_stall = 0;
        end else begin
            be_rsp_valid = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    be_rsp_valid = 1'b1;
                    be_rsp_ack   = p_ack;
                    be_rsp_data  = p_data;
                    pend = 0;
                end else dly--;
            end
            if (prev_stall && (!be_cmd_valid ||
                {be_cmd_op, be_cmd_last, be_cmd_data} != prev_fields))
                stall_viol++;
            r = ($urandom_range(0, 3) != 0);
            be_cmd_ready = r;
            prev_stall  = be_cmd_valid && !r;
            prev_fields = {be_cmd_op, be_cmd_last, be_cmd_data};
            if (be_cmd_valid && r) begin
                cmd_log.push_back({be_cmd_op, (be_cmd_op == C_READ) ? be_cmd_last : 1'b0,
                                   (be_cmd_op == C_WRITE) ? be_cmd_data : 8'h00});
                p_ack = 1'b1; p_data = 8'h00;
                case (be_cmd_op)
                    C_START: begin
                        for (int i = 0; i < 8; i++) begin e_asg[i] = 0; e_nack[i] = sc_nack[i]; end
                        expect_hdr = 1; rd_idx = 0;
                    end
                    C_RESTART: expect_hdr = 1;
                    C_WRITE: begin
                        if (expect_hdr) begin
                            expect_hdr = 0;
                            if (be_cmd_data == 8'hFC) p_ack = sc_bcast_ack;
                            else begin
                                cur = -1;
                                for (int i = sc_n - 1; i >= 0; i--) if (!e_asg[i]) cur = i;
                                p_ack = (cur >= 0);
                                rd_idx = 0;
                            end
                        end else if (rd_idx == 8) begin
                            if (e_nack[cur] > 0) begin e_nack[cur]--; p_ack = 1'b0; end
                            else e_asg[cur] = 1;
                            rd_idx = 0;
                        end
                    end
                    C_READ: begin
                        tmp = sc_bytes[cur] >> (8 * (7 - rd_idx));
                        p_data = tmp[7:0];
                        rd_idx++;
                        reads_acc++;
                    end
                    default: ;
                endcase
                pend = 1;
                dly  = $urandom_range(0, 2);
            end
        end
    end

    // Output monitor
    logic [70:0] dev_log[$];
    int          done_cnt = 0;
    always @(negedge clk) begin
        if (new_dev_valid) dev_log.push_back({new_dev_da, new_dev_pid, new_dev_bcr, new_dev_dcr});
        if (done) done_cnt++;
    end

    // Reference model
    int          m_count = 0;
    logic        m_err = 0, m_hj = 0;
    logic [11:0] exp_cmds[$];
    logic [70:0] exp_devs[$];

    task automatic model_seq(input logic [7:0] code);
        bit asg [8];
        int nk  [8];
        int idx;
        logic [6:0] da;
        logic par;
        exp_cmds.delete();
        exp_devs.delete();
        exp_cmds.push_back({C_START, 1'b0, 8'h00});
        exp_cmds.push_back({C_WRITE, 1'b0, 8'hFC});
        if (!sc_bcast_ack) begin
            exp_cmds.push_back({C_STOP, 1'b0, 8'h00});
            if (code == 8'h07) m_hj = 0;
            return;
        end
        exp_cmds.push_back({C_WRITE, 1'b0, code});
        if (code == 8'h00 || code == 8'h01) exp_cmds.push_back({C_WRITE, 1'b0, 8'h08});
        if (code == 8'h07) begin
            for (int i = 0; i < 8; i++) begin asg[i] = 0; nk[i] = sc_nack[i]; end
            forever begin
                if (m_count == MAX_DEV) begin m_err = 1; break; end
                exp_cmds.push_back({C_RESTART, 1'b0, 8'h00});
                exp_cmds.push_back({C_WRITE, 1'b0, 8'hFD});
                idx = -1;
                for (int i = 0; i < sc_n; i++) if (idx < 0 && !asg[i]) idx = i;
                if (idx < 0) break;
                for (int b = 0; b < 8; b++) exp_cmds.push_back({C_READ, (b == 7), 8'h00});
                da  = 7'(16 + m_count);
                par = ($countones(da) % 2 == 0);
                exp_cmds.push_back({C_WRITE, 1'b0, {da, par}});
                if (nk[idx] > 0) nk[idx]--;
                else begin
                    asg[idx] = 1;
                    exp_devs.push_back({da, sc_bytes[idx]});
                    m_count++;
                end
            end
            m_hj = 0;
        end
        exp_cmds.push_back({C_STOP, 1'b0, 8'h00});
        if (code == 8'h06) begin m_count = 0; m_err = 0; end
    endtask

    task automatic pulse_req(input logic [7:0] code);
        @(negedge clk);
        case (code)
            8'h06:   rstdaa_req   = 1'b1;
            8'h01:   disec_hj_req = 1'b1;
            8'h00:   enec_hj_req  = 1'b1;
            default: entdaa_req   = 1'b1;
        endcase
        @(negedge clk);
        rstdaa_req = 1'b0; disec_hj_req = 1'b0; enec_hj_req = 1'b0; entdaa_req = 1'b0;
    endtask

    task automatic run_seq(input string nm, input logic [7:0] code);
        int base_c, base_d, base_done, cyc, n;
        model_seq(code);
        base_c = cmd_log.size(); base_d = dev_log.size(); base_done = done_cnt;
        pulse_req(code);
        cyc = 0;
        while (done_cnt == base_done && cyc < 3000) begin @(negedge clk); cyc++; end
        if (cyc >= 3000) chk({nm, " done_timeout"}, 64'(cyc), 64'd0);
        repeat (2) @(negedge clk);
        chk({nm, " done_pulses"}, 64'(done_cnt - base_done), 64'd1);
        chk({nm, " ncmd"}, 64'(cmd_log.size() - base_c), 64'(exp_cmds.size()));
        n = exp_cmds.size();
        if (cmd_log.size() - base_c < n) n = cmd_log.size() - base_c;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s cmd%0d", nm, i), 64'(cmd_log[base_c + i]), 64'(exp_cmds[i]));
            if (cmd_log[base_c + i] !== exp_cmds[i]) break;
        end
        chk({nm, " ndev"}, 64'(dev_log.size() - base_d), 64'(exp_devs.size()));
        n = exp_devs.size();
        if (dev_log.size() - base_d < n) n = dev_log.size() - base_d;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s dev%0d_da", nm, i), 64'(dev_log[base_d + i][70:64]), 64'(exp_devs[i][70:64]));
            chk($sformatf("%s dev%0d_id", nm, i), dev_log[base_d + i][63:0], exp_devs[i][63:0]);
        end
        chk({nm, " dev_count"}, 64'(dev_count), 64'(m_count));
        chk({nm, " err_pool_full"}, 64'(err_pool_full), 64'(m_err));
        chk({nm, " hj_pending"}, 64'(hj_pending), 64'(m_hj));
        chk({nm, " busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_ibi(input string nm, input logic [6:0] a, input logic rnw, input logic en);
        logic exp;
        exp = (a == 7'h02) && !rnw && en;
        @(negedge clk);
        ibi_valid = 1'b1; ibi_addr = a; ibi_rnw = rnw; hj_en = en;
        @(negedge clk);
        ibi_valid = 1'b0;
        chk({nm, " ibi_ready"}, 64'(ibi_ready), 64'd1);
        chk({nm, " ibi_ack"}, 64'(ibi_ack), 64'(exp));
        if (exp) m_hj = 1;
        @(negedge clk);
        chk({nm, " ibi_ready_pulse"}, 64'(ibi_ready), 64'd0);
        chk({nm, " hj_pending"}, 64'(hj_pending), 64'(m_hj));
    endtask

    task automatic set_targets(input int n, input int max_nack, input logic back);
        sc_n = n;
        sc_bcast_ack = back;
        for (int i = 0; i < 8; i++) begin
            sc_bytes[i] = {$urandom, $urandom};
            sc_nack[i]  = (max_nack > 0) ? $urandom_range(0, max_nack) : 0;
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " be_cmd_valid"}, 64'(be_cmd_valid), 64'd0);
        chk({nm, " busy"}, 64'(busy), 64'd0);
        chk({nm, " done"}, 64'(done), 64'd0);
        chk({nm, " ibi_ready"}, 64'({ibi_ready, ibi_ack}), 64'd0);
        chk({nm, " err_pool_full"}, 64'(err_pool_full), 64'd0);
        chk({nm, " dev_count"}, 64'(dev_count), 64'd0);
        chk({nm, " hj_pending"}, 64'(hj_pending), 64'd0);
        chk({nm, " new_dev"}, 64'({new_dev_valid, new_dev_da, new_dev_bcr, new_dev_dcr}), 64'd0);
        chk({nm, " new_dev_pid"}, 64'(new_dev_pid), 64'd0);
    endtask

    initial begin
        int k, base_r, cyc;
        rst_n = 1'b0;
        ibi_valid = 1'b0; ibi_addr = 7'h00; ibi_rnw = 1'b0; hj_en = 1'b0;
        rstdaa_req = 1'b0; entdaa_req = 1'b0; enec_hj_req = 1'b0; disec_hj_req = 1'b0;
        set_targets(0, 0, 1'b1);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Hot-Join IBIs
        run_ibi("ibi_hj_en0", 7'h02, 1'b0, 1'b0);
        run_ibi("ibi_hj_rnw", 7'h02, 1'b1, 1'b1);
        run_ibi("ibi_other", 7'h33, 1'b0, 1'b1);
        run_ibi("ibi_hj", 7'h02, 1'b0, 1'b1);

        // Two targets, the first NACKs its address once
        set_targets(2, 0, 1'b1);
        sc_bytes[0] = {48'h123456789ABC, 8'h06, 8'h00};
        sc_nack[0]  = 1;
        run_seq("entdaa2", 8'h07);

        set_targets(0, 0, 1'b1);
        run_seq("disec", 8'h01);
        run_seq("enec", 8'h00);
        run_seq("rstdaa", 8'h06);

        // Pool exhaustion: more targets than addresses
        set_targets(6, 0, 1'b1);
        run_seq("full", 8'h07);
        set_targets(0, 0, 1'b1);
        run_seq("rstdaa_clr", 8'h06);

        // Randomised mix
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 5);
            if (k == 0) begin
                run_ibi($sformatf("r%0d_ibi", it),
                        ($urandom_range(0, 2) == 0) ? 7'h02 : 7'($urandom),
                        1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
            end else begin
                set_targets($urandom_range(0, 3), 2, 1'($urandom_range(0, 9) != 0));
                case (k)
                    1:       run_seq($sformatf("r%0d_rstdaa", it), 8'h06);
                    2:       run_seq($sformatf("r%0d_enec", it), 8'h00);
                    3:       run_seq($sformatf("r%0d_disec", it), 8'h01);
                    default: run_seq($sformatf("r%0d_entdaa", it), 8'h07);
                endcase
            end
        end

        // Reset in the middle of the 4th READ
        set_targets(0, 0, 1'b1);
        run_seq("pre_rst_rstdaa", 8'h06);
        run_ibi("pre_rst_ibi", 7'h02, 1'b0, 1'b1);
        set_targets(2, 0, 1'b1);
        base_r = reads_acc;
        pulse_req(8'h07);
        cyc = 0;
        while (reads_acc < base_r + 4 && cyc < 2000) begin @(negedge clk); cyc++; end
        if (cyc >= 2000) chk("midrst read_timeout", 64'(cyc), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        m_count = 0; m_err = 0; m_hj = 0;
        repeat (2) @(negedge clk);
        set_targets(1, 0, 1'b1);
        run_seq("post_rst", 8'h07);
        chk("post_rst first_da", 64'(dev_log[dev_log.size() - 1][70:64]), 64'h10);

        chk("cmd_stable_while_stalled", 64'(stall_viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
